data_mem_responder: RTL and testbench

- Data-side responder for the pipelined CPU's MEM-stage memory port.
- Decodes address, mem_w and DMType from the core and serves word-organised RAM with byte-lane stores and sign- or zero-extended sub-word loads.
- Also serves a small memory-mapped I/O window: LED register, switch input, cycle counter and a sticky misalignment status.
- Reads are combinational, because the core samples load data in the same cycle. Writes commit on the rising clock edge.

---
 rtl/data_mem_responder.sv | 144 ++++++++++++++
 tb/tb_data_mem_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-side MEM-stage responder: word-organised RAM with byte-lane stores and
// extended sub-word loads, plus a small MMIO window (LED, switches, cycle counter, error status).
module data_mem_responder #(
  parameter int          DEPTH_WORDS  = 1024,
  parameter logic [15:0] MMIO_BASE_HI = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  dm_type,
  output logic [31:0] rdata,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic        misalign_err,
  output logic [31:0] err_addr
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   cycle_cnt;
  logic          is_ram;
  logic          is_mmio;
  logic          is_half;
  logic          is_byte;
  logic          aligned;
  logic [AW-1:0] widx;
  logic [31:0]   mmio_word;
  logic [31:0]   raw_word;
  logic [31:0]   lane_word;
  logic [31:0]   store_data;
  logic [3:0]    be;
  logic          ram_wr;
  logic          mmio_wr;
  logic          misaligned_st;

  // Region, access size and alignment decode
  always_comb begin
    is_ram  = (addr < RAM_BYTES);
    is_mmio = (addr[31:16] == MMIO_BASE_HI);
    widx    = addr[AW+1:2];
    case (dm_type)
      3'b001, 3'b010: begin is_half = 1'b1; is_byte = 1'b0; end
      3'b011, 3'b100: begin is_half = 1'b0; is_byte = 1'b1; end
      default:        begin is_half = 1'b0; is_byte = 1'b0; end
    endcase
    if (is_byte) begin
      aligned = 1'b1;
    end else if (is_half) begin
      aligned = (addr[0] == 1'b0);
    end else begin
      aligned = (addr[1:0] == 2'b00);
    end
  end

  // MMIO register read mux; sub-word loads pick their lane from the whole register
  always_comb begin
    case (addr[15:2])
      14'd0:   mmio_word = {16'h0000, led_out};
      14'd1:   mmio_word = {16'h0000, sw_in};
      14'd2:   mmio_word = cycle_cnt;
      14'd3:   mmio_word = {31'd0, misalign_err};
      14'd4:   mmio_word = err_addr;
      default: mmio_word = 32'h0000_0000;
    endcase
  end

  // Combinational load path: the core samples rdata in the same cycle
  always_comb begin
    if (is_ram) begin
      raw_word = mem[widx];
    end else if (is_mmio) begin
      raw_word = mmio_word;
    end else begin
      raw_word = 32'h0000_0000;
    end
    lane_word = raw_word >> {addr[1:0], 3'b000};
    if (!aligned) begin
      rdata = 32'h0000_0000;
    end else begin
      case (dm_type)
        3'b001:  rdata = {{16{lane_word[15]}}, lane_word[15:0]};
        3'b010:  rdata = {16'h0000, lane_word[15:0]};
        3'b011:  rdata = {{24{lane_word[7]}}, lane_word[7:0]};
        3'b100:  rdata = {24'h000000, lane_word[7:0]};
        default: rdata = raw_word;
      endcase
    end
  end

  // Store lane enables and replicated store data
  always_comb begin
    if (is_byte) begin
      be         = 4'b0001 << addr[1:0];
      store_data = {4{wdata[7:0]}};
    end else if (is_half) begin
      be         = addr[1] ? 4'b1100 : 4'b0011;
      store_data = {2{wdata[15:0]}};
    end else begin
      be         = 4'b1111;
      store_data = wdata;
    end
    ram_wr        = mem_w && !rst && aligned && is_ram;
    mmio_wr       = mem_w && !rst && aligned && is_mmio && !is_half && !is_byte;
    misaligned_st = mem_w && !aligned;
  end

  // RAM array write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[widx][8*i +: 8] <= store_data[8*i +: 8];
        end
      end
    end
  end

  // MMIO registers and sticky misalignment capture (first error address wins)
  always_ff @(posedge clk) begin
    if (rst) begin
      led_out      <= 16'h0000;
      misalign_err <= 1'b0;
      err_addr     <= 32'h0000_0000;
      cycle_cnt    <= 32'h0000_0000;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (mmio_wr && (addr[15:0] == 16'h0000)) begin
        led_out <= wdata[15:0];
      end
      if (misaligned_st && !misalign_err) begin
        misalign_err <= 1'b1;
        err_addr     <= addr;
      end else if (mmio_wr && (addr[15:0] == 16'h000C) && wdata[0]) begin
        misalign_err <= 1'b0;
        err_addr     <= 32'h0000_0000;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: byte-level reference model checked
// every cycle, plus directed vectors with hand-computed expectations.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        mem_w;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  dm_type;
  logic [31:0] rdata;
  logic [15:0] sw_in;
  logic [15:0] led_out;
  logic        misalign_err;
  logic [31:0] err_addr;

  int errors = 0;
  int checks = 0;

  data_mem_responder dut (
    .clk(clk), .rst(rst), .mem_w(mem_w), .addr(addr), .wdata(wdata),
    .dm_type(dm_type), .rdata(rdata), .sw_in(sw_in), .led_out(led_out),
    .misalign_err(misalign_err), .err_addr(err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: byte-addressed RAM image with per-byte "written" marks
  logic [7:0]  mb [0:4095];
  bit          kn [0:4095];
  logic [15:0] m_led;
  logic        m_err;
  logic [31:0] m_eaddr;
  logic [31:0] m_cycle;
  bit          started = 1'b0;

  task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string nm);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int acc_size(input logic [2:0] t);
    if (t == 3'd1 || t == 3'd2) return 2;
    if (t == 3'd3 || t == 3'd4) return 1;
    return 4;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [2:0] t);
    int n;
    logic [31:0] v;
    logic [31:0] r;
    logic [15:0] off;
    n = acc_size(t);
    v = 32'h0;
    if ((a % n) != 0) return 32'h0;
    if (a < 32'd4096) begin
      for (int i = 0; i < n; i++) v = v | (32'(mb[a + i]) << (8 * i));
    end else if (a[31:16] == 16'hFFFF) begin
      off = {a[15:2], 2'b00};
      if (off == 16'h0000)      r = {16'h0, m_led};
      else if (off == 16'h0004) r = {16'h0, sw_in};
      else if (off == 16'h0008) r = m_cycle;
      else if (off == 16'h000C) r = {31'h0, m_err};
      else if (off == 16'h0010) r = m_eaddr;
      else                      r = 32'h0;
      v = r >> (8 * (a % 4));
      if (n < 4) v = v & ((32'h1 << (8 * n)) - 32'h1);
    end
    if (t == 3'd1) v = {{16{v[15]}}, v[15:0]};
    if (t == 3'd3) v = {{24{v[7]}}, v[7:0]};
    return v;
  endfunction

  function automatic bit exp_known(input logic [31:0] a, input logic [2:0] t);
    int n;
    n = acc_size(t);
    if ((a % n) != 0 || a >= 32'd4096) return 1'b1;
    for (int i = 0; i < n; i++) if (!kn[a + i]) return 1'b0;
    return 1'b1;
  endfunction

  // Model state update at each clock edge
  always @(posedge clk) begin
    if (rst) begin
      m_led   <= 16'h0;
      m_err   <= 1'b0;
      m_eaddr <= 32'h0;
      m_cycle <= 32'h0;
      started <= 1'b1;
    end else begin
      m_cycle <= m_cycle + 32'd1;
      if (mem_w) begin
        if ((addr % acc_size(dm_type)) != 0) begin
          if (!m_err) begin
            m_err   <= 1'b1;
            m_eaddr <= addr;
          end
        end else if (addr < 32'd4096) begin
          for (int i = 0; i < acc_size(dm_type); i++) begin
            mb[addr + i] <= wdata[8*i +: 8];
            kn[addr + i] <= 1'b1;
          end
        end else if (addr[31:16] == 16'hFFFF && acc_size(dm_type) == 4) begin
          if (addr[15:0] == 16'h0000) m_led <= wdata[15:0];
          if (addr[15:0] == 16'h000C && wdata[0]) begin
            m_err   <= 1'b0;
            m_eaddr <= 32'h0;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      if (exp_known(addr, dm_type)) chk(rdata, exp_load(addr, dm_type), "rdata_model");
      chk({16'h0, led_out}, {16'h0, m_led}, "led_model");
      chk({31'h0, misalign_err}, {31'h0, m_err}, "err_model");
      chk(err_addr, m_eaddr, "eaddr_model");
    end
  end

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    mem_w = 1'b1; addr = a; wdata = d; dm_type = t;
    @(posedge clk); #1;
    mem_w = 1'b0;
  endtask

  task automatic ld(input logic [31:0] a, input logic [2:0] t, input logic [31:0] exp, input string nm);
    mem_w = 1'b0; addr = a; dm_type = t;
    #2;
    chk(rdata, exp, nm);
    @(posedge clk); #1;
  endtask

  logic [31:0] c0;
  logic [31:0] c1;

  initial begin
    rst = 1'b1; mem_w = 1'b0; addr = 32'h0; wdata = 32'h0; dm_type = 3'd0; sw_in = 16'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk({16'h0, led_out}, 32'h0, "reset_led");
    chk({31'h0, misalign_err}, 32'h0, "reset_err");
    chk(err_addr, 32'h0, "reset_eaddr");

    // Byte loads with sign and zero extension
    st(32'h10, 32'h80FF7F01, 3'd0);
    ld(32'h10, 3'd3, 32'h00000001, "lb_10");
    ld(32'h11, 3'd3, 32'h0000007F, "lb_11");
    ld(32'h12, 3'd3, 32'hFFFFFFFF, "lb_12");
    ld(32'h13, 3'd3, 32'hFFFFFF80, "lb_13");
    ld(32'h13, 3'd4, 32'h00000080, "lbu_13");

    // Old data visible in the store cycle, new data next cycle
    mem_w = 1'b1; addr = 32'h10; wdata = 32'h00000055; dm_type = 3'd0;
    #2 chk(rdata, 32'h80FF7F01, "no_write_through");
    @(posedge clk); #1;
    mem_w = 1'b0;
    ld(32'h10, 3'd0, 32'h00000055, "store_visible");

    // Halfword store into upper lane
    st(32'h20, 32'hAAAAAAAA, 3'd0);
    st(32'h22, 32'h12348001, 3'd1);
    ld(32'h20, 3'd0, 32'h8001AAAA, "sh_merge");
    ld(32'h22, 3'd1, 32'hFFFF8001, "lh_22");
    ld(32'h22, 3'd2, 32'h00008001, "lhu_22");
    ld(32'h21, 3'd1, 32'h00000000, "lh_misaligned");

    // Misaligned stores: suppressed, first address sticks, cleared by STATUS write of 1
    st(32'h40, 32'h11223344, 3'd0);
    st(32'h41, 32'hFFFFFFFF, 3'd0);
    chk({31'h0, misalign_err}, 32'h1, "err_set");
    chk(err_addr, 32'h41, "eaddr_first");
    ld(32'h40, 3'd0, 32'h11223344, "misaligned_suppressed");
    st(32'h43, 32'h0000BEEF, 3'd1);
    chk(err_addr, 32'h41, "eaddr_kept");
    ld(32'hFFFF000C, 3'd0, 32'h00000001, "status_read");
    ld(32'hFFFF0010, 3'd0, 32'h00000041, "erraddr_read");
    st(32'hFFFF000C, 32'h00000000, 3'd0);
    chk({31'h0, misalign_err}, 32'h1, "status_write0_noop");
    st(32'hFFFF000C, 32'h00000001, 3'd0);
    chk({31'h0, misalign_err}, 32'h0, "err_cleared");
    chk(err_addr, 32'h0, "eaddr_cleared");

    // LED and switch registers
    st(32'hFFFF0000, 32'hDEAD5A5A, 3'd0);
    chk({16'h0, led_out}, 32'h5A5A, "led_write");
    st(32'hFFFF0000, 32'h00000077, 3'd3);
    chk({16'h0, led_out}, 32'h5A5A, "led_sb_ignored");
    st(32'hFFFF0004, 32'h0000FFFF, 3'd0);
    sw_in = 16'h00C3;
    ld(32'hFFFF0004, 3'd0, 32'h000000C3, "sw_read");
    ld(32'hFFFF0000, 3'd4, 32'h0000005A, "led_lbu");
    ld(32'hFFFF0002, 3'd1, 32'h00000000, "led_upper_half");
    ld(32'hFFFF0020, 3'd0, 32'h00000000, "mmio_other");

    // Cycle counter delta over five cycles
    mem_w = 1'b0; addr = 32'hFFFF0008; dm_type = 3'd0;
    #2 c0 = rdata;
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    #2 c1 = rdata;
    chk(c1 - c0, 32'd5, "cycle_delta");
    @(posedge clk); #1;

    // Reset with a pending LED store
    mem_w = 1'b1; addr = 32'hFFFF0000; wdata = 32'h0000BEEF; dm_type = 3'd0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_w = 1'b0;
    chk({16'h0, led_out}, 32'h0, "rst_drops_store");
    ld(32'hFFFF0008, 3'd0, 32'h00000000, "cycle_after_rst");
    ld(32'h40, 3'd0, 32'h11223344, "ram_survives_rst");

    // Unmapped store aliasing onto word 0 must not land
    st(32'h00000000, 32'h0BADF00D, 3'd0);
    st(32'h00010000, 32'hFFFFFFFF, 3'd0);
    ld(32'h00010000, 3'd0, 32'h00000000, "unmapped_read");
    ld(32'h00000000, 3'd0, 32'h0BADF00D, "unmapped_no_alias");
    chk({31'h0, misalign_err}, 32'h0, "unmapped_no_err");
    st(32'h00000FFF, 32'h000000A5, 3'd3);
    ld(32'h00000FFF, 3'd4, 32'h000000A5, "last_ram_byte");
    ld(32'h00001000, 3'd0, 32'h00000000, "past_ram_end");

    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
